// File: rtl/fir_mon_pkg.sv
// Shared types and constants for the FIR round monitor: FSM states, marker words,
// register-map addresses and status-word bit positions.
package fir_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_FULL  = 2'd3
  } mon_state_e;

  localparam logic [15:0] ARM_MARK_DEF   = 16'hAB40;
  localparam logic [15:0] START_MARK_DEF = 16'h00A5;
  localparam logic [15:0] END_MARK_DEF   = 16'h765A;

  localparam logic [3:0] ADDR_STATUS    = 4'd0;
  localparam logic [3:0] ADDR_SLOT_BASE = 4'd1;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_FULL_BIT  = 3;
  localparam int STAT_TMO_BIT   = 4;
  localparam int STAT_IDX_LSB   = 16;
  localparam int STAT_ABORT_LSB = 24;

  // Each round owns two consecutive words: latency first, then sample count.
  function automatic logic [3:0] lat_addr(input int slot);
    return 4'(int'(ADDR_SLOT_BASE) + 2 * slot);
  endfunction

  function automatic logic [3:0] smp_addr(input int slot);
    return 4'(int'(ADDR_SLOT_BASE) + 2 * slot + 1);
  endfunction

endpackage

// File: rtl/fir_round_monitor_if.sv
// Bus bundle between the FIR round monitor and its user: monitored status word,
// clear, registered read port and status flags.
interface fir_round_monitor_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] chk_i;
  logic              clr_i;
  logic              rd_en_i;
  logic [3:0]        rd_addr_i;
  logic [31:0]       rd_data_o;
  logic              rd_valid_o;
  logic              busy_o;
  logic              round_done_o;
  logic              full_o;

  modport master (
    output chk_i, clr_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, busy_o, round_done_o, full_o
  );

  modport slave (
    input  chk_i, clr_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, busy_o, round_done_o, full_o
  );
endinterface

// File: rtl/fir_mon_regfile.sv
// Per-round result storage (latency and sample count) with a registered read mux;
// address 0 returns the status word supplied by the monitor FSM.
module fir_mon_regfile
  import fir_mon_pkg::*;
#(
  parameter int NUM_ROUNDS = 3,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [2:0]       widx,
  input  logic [CNT_W-1:0] wlat,
  input  logic [CNT_W-1:0] wsmp,
  input  logic [31:0]      status,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             rd_valid
);

  logic [CNT_W-1:0] lat_q [NUM_ROUNDS];
  logic [CNT_W-1:0] smp_q [NUM_ROUNDS];
  logic [31:0]      rd_mux;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        lat_q[i] <= '0;
        smp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        if (we && widx == 3'(i)) begin
          lat_q[i] <= wlat;
          smp_q[i] <= wsmp;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_addr == ADDR_STATUS) rd_mux = status;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (rd_addr == lat_addr(i)) rd_mux = 32'(lat_q[i]);
      if (rd_addr == smp_addr(i)) rd_mux = 32'(smp_q[i]);
    end
  end

  // A clear must not drop a read already in flight, so only reset touches this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/fir_round_monitor.sv
// Watches the FIR status word for arm/start/end markers and records per-round latency
// and distinct-sample counts. Optional watchdog enabled by macro FIR_MON_TIMEOUT_EN.
module fir_round_monitor
  import fir_mon_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] ARM_MARK   = ARM_MARK_DEF,
  parameter logic [DATA_W-1:0] START_MARK = START_MARK_DEF,
  parameter logic [DATA_W-1:0] END_MARK   = END_MARK_DEF,
  parameter int                NUM_ROUNDS = 3,
  parameter int                CNT_W      = 32,
  parameter int                TIMEOUT    = 250000
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  fir_round_monitor_if.slave    bus
);

  mon_state_e        state_q, state_d;
  logic [DATA_W-1:0] chk_q, prev_q;
  logic [CNT_W-1:0]  lat_cnt_q, smp_cnt_q, lat_plus;
  logic [7:0]        abort_cnt_q;
  logic [2:0]        idx_q;
  logic              round_done_q;
  logic              timeout_q;
  logic              rec_we, cnt_clr, cnt_inc, smp_inc, abort, tmo;
  logic [CNT_W-1:0]  rec_lat;
  logic [31:0]       status;
  logic              last_slot;

`ifdef FIR_MON_TIMEOUT_EN
  logic [CNT_W-1:0]  wd_q;
`else
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_q      = 1'b0;
`endif

  assign lat_plus  = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + CNT_W'(1);
  assign last_slot = (idx_q == 3'(NUM_ROUNDS - 1));

  // A round closes one edge after its last data word, so the END edge itself counts.
  always_comb begin
    state_d = state_q;
    rec_we  = 1'b0;
    rec_lat = lat_plus;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    smp_inc = 1'b0;
    abort   = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: if (chk_q == ARM_MARK) state_d = ST_ARMED;
      ST_ARMED: begin
        if (chk_q == START_MARK) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (chk_q == END_MARK) begin
          rec_we  = 1'b1;
          state_d = last_slot ? ST_FULL : ST_ARMED;
        end else if (chk_q == START_MARK) begin
          cnt_clr = 1'b1;
          abort   = 1'b1;
        end
`ifdef FIR_MON_TIMEOUT_EN
        else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
          rec_we  = 1'b1;
          rec_lat = '1;
          tmo     = 1'b1;
          state_d = last_slot ? ST_FULL : ST_ARMED;
        end
`endif
        else begin
          cnt_inc = 1'b1;
          smp_inc = (chk_q != prev_q);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || bus.clr_i) begin
      state_q      <= ST_IDLE;
      chk_q        <= '0;
      prev_q       <= '0;
      lat_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      abort_cnt_q  <= '0;
      idx_q        <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chk_q        <= bus.chk_i;
      prev_q       <= chk_q;
      round_done_q <= rec_we;
      if (rec_we) idx_q <= idx_q + 3'd1;
      if (cnt_clr) begin
        lat_cnt_q <= '0;
        smp_cnt_q <= '0;
      end else if (cnt_inc) begin
        lat_cnt_q <= lat_plus;
        if (smp_inc) smp_cnt_q <= smp_cnt_q + CNT_W'(1);
      end
      if (abort && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

`ifdef FIR_MON_TIMEOUT_EN
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || bus.clr_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (cnt_clr) wd_q <= '0;
      else if (state_q == ST_RUN) wd_q <= wd_q + CNT_W'(1);
      if (tmo) timeout_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    status                              = '0;
    status[STAT_ABORT_LSB +: 8]         = abort_cnt_q;
    status[STAT_IDX_LSB +: 3]           = idx_q;
    status[STAT_TMO_BIT]                = timeout_q;
    status[STAT_FULL_BIT]               = (state_q == ST_FULL);
    status[STAT_STATE_LSB +: 2]         = state_q;
  end

  fir_mon_regfile #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_regfile (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .clr      (bus.clr_i),
    .we       (rec_we),
    .widx     (idx_q),
    .wlat     (rec_lat),
    .wsmp     (smp_cnt_q),
    .status   (status),
    .rd_en    (bus.rd_en_i),
    .rd_addr  (bus.rd_addr_i),
    .rd_data  (bus.rd_data_o),
    .rd_valid (bus.rd_valid_o)
  );

  assign bus.busy_o       = (state_q == ST_RUN);
  assign bus.full_o       = (state_q == ST_FULL);
  assign bus.round_done_o = round_done_q;

endmodule

// File: tb/tb_fir_round_monitor.sv
// Scoreboard bench for fir_round_monitor: reads push expected words, a forked monitor
// pops them when rd_valid_o appears and also counts round_done_o pulses.
module tb_fir_round_monitor;

`ifdef FIR_MON_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 250000;
`endif

  typedef struct {
    logic [31:0] data;
    string       name;
    int          cyc;
  } exp_t;

  logic axis_clk;
  logic axis_rst_n;
  int   cyc;
  int   n_total;
  int   n_bad;
  int   pulses;
  exp_t sb[$];

  fir_round_monitor_if #(.DATA_W(16)) bus();

  fir_round_monitor #(
    .NUM_ROUNDS (3),
    .CNT_W      (32),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic [15:0] v);
    bus.chk_i = v;
    @(negedge axis_clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(16'h0000);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issued at a negedge; the response is due at the following negedge.
  task automatic doRead(input logic [3:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.name = name;
    e.cyc  = cyc;
    sb.push_back(e);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = addr;
    @(negedge axis_clk);
    bus.rd_en_i   = 1'b0;
    bus.rd_addr_i = 4'd0;
  endtask

  task automatic runRound(input logic [15:0] base, input int n);
    applyStimulus(16'hAB40);
    applyStimulus(16'h00A5);
    for (int i = 0; i < n; i++) applyStimulus(base + 16'(i));
    applyStimulus(16'h765A);
  endtask

  task automatic pulseClear();
    bus.clr_i = 1'b1;
    @(negedge axis_clk);
    bus.clr_i = 1'b0;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    pulses        = 0;
    axis_rst_n    = 1'b0;
    bus.chk_i     = '0;
    bus.clr_i     = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.rd_addr_i = '0;

    fork
      begin
        exp_t e;
        forever begin
          @(negedge axis_clk);
          if (bus.round_done_o) pulses++;
          if (bus.rd_valid_o) begin
            n_total++;
            if (sb.size() == 0) begin
              n_bad++;
              $display("[TB] FAIL unexpected_rd_valid: got data %h, want no valid", bus.rd_data_o);
            end else begin
              e = sb.pop_front();
              if (bus.rd_data_o !== e.data || cyc != e.cyc + 1) begin
                n_bad++;
                $display("[TB] FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                         e.name, bus.rd_data_o, cyc, e.data, e.cyc + 1);
              end
            end
          end
        end
      end
    join_none

    repeat (5) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // Reset state
    checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("reset_full", 32'(bus.full_o), 32'd0);
    doRead(4'd0, 32'h0000_0000, "reset_status");
    doRead(4'd1, 32'h0000_0000, "reset_lat0");

    // Single round, with a read colliding with the slot write
    runRound(16'h1000, 64);
    doRead(4'd1, 32'd0, "lat0_same_cycle_write");
    idleCycles(3);
    doRead(4'd1, 32'd65, "r1_lat0");
    doRead(4'd2, 32'd64, "r1_smp0");
    doRead(4'd0, 32'h0001_0001, "r1_status");
    idleCycles(2);
    checkOutput("r1_pulses", 32'(pulses), 32'd1);
    checkOutput("r1_busy", 32'(bus.busy_o), 32'd0);

    // Rounds two and three fill the slots
    idleCycles(100);
    runRound(16'h3000, 64);
    idleCycles(100);
    runRound(16'h4000, 64);
    idleCycles(3);
    checkOutput("r3_full", 32'(bus.full_o), 32'd1);
    doRead(4'd3, 32'd65, "r3_lat1");
    doRead(4'd5, 32'd65, "r3_lat2");
    doRead(4'd6, 32'd64, "r3_smp2");
    doRead(4'd0, 32'h0003_000B, "r3_status");
    doRead(4'd7, 32'd0, "unmapped_addr7");
    doRead(4'd15, 32'd0, "unmapped_addr15");
    applyStimulus(16'h00A5);
    idleCycles(3);
    checkOutput("full_ignores_start_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("full_ignores_start_full", 32'(bus.full_o), 32'd1);
    checkOutput("r3_pulses", 32'(pulses), 32'd3);

    // Restart abort
    pulseClear();
    applyStimulus(16'hAB40);
    applyStimulus(16'h00A5);
    for (int i = 0; i < 10; i++) applyStimulus(16'h2000 + 16'(i));
    applyStimulus(16'h00A5);
    for (int i = 0; i < 5; i++) applyStimulus(16'h2100 + 16'(i));
    applyStimulus(16'h765A);
    idleCycles(3);
    doRead(4'd1, 32'd6, "abort_lat0");
    doRead(4'd2, 32'd5, "abort_smp0");
    doRead(4'd0, 32'h0101_0001, "abort_status");

    // Clear in the middle of a round
    applyStimulus(16'h00A5);
    for (int i = 0; i < 4; i++) applyStimulus(16'h5000 + 16'(i));
    checkOutput("midrun_busy", 32'(bus.busy_o), 32'd1);
    pulseClear();
    checkOutput("clr_busy", 32'(bus.busy_o), 32'd0);
    doRead(4'd0, 32'd0, "clr_status");
    doRead(4'd1, 32'd0, "clr_lat0");
    doRead(4'd2, 32'd0, "clr_smp0");

    // Stray markers before arming
    applyStimulus(16'h765A);
    applyStimulus(16'h00A5);
    idleCycles(3);
    checkOutput("stray_busy", 32'(bus.busy_o), 32'd0);
    doRead(4'd0, 32'd0, "stray_status");

`ifdef FIR_MON_TIMEOUT_EN
    pulseClear();
    applyStimulus(16'hAB40);
    applyStimulus(16'h00A5);
    idleCycles(110);
    doRead(4'd1, 32'hFFFF_FFFF, "tmo_lat0");
    doRead(4'd2, 32'd1, "tmo_smp0");
    doRead(4'd0, 32'h0001_0011, "tmo_status");
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge axis_clk);
    if (sb.size() != 0) begin
      n_total++;
      n_bad++;
      $display("[TB] FAIL read_drain: got %0d pending reads, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
